uart_loop_ctrl: RTL and testbench

Parametrised loopback/echo controller between a UART's RX FIFO read port and TX FIFO write port. It replaces the fixed "pop and push on a button tick" loop with four selectable modes, an optional per-byte data transform, a burst length, and a saturating byte counter plus miss flag for status LEDs. It sits in the board-level UART test top, after the debounce and tick logic, and drives the UART's rd_uart, wr_uart and w_data.

---
 rtl/uart_loop_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_loop_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loop_ctrl.sv
// Loopback/echo controller between a UART RX FIFO read port and TX FIFO write port.
// Supports OFF/STEP/AUTO/BURST modes, a per-byte transform and saturating status counters.
module uart_loop_ctrl #(
   parameter int unsigned DBIT      = 8,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned BURST_LEN = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic [1:0]       xform,
   input  logic             step,
   input  logic             clr,
   input  logic             rx_empty,
   input  logic [DBIT-1:0]  r_data,
   input  logic             tx_full,
   output logic             rd_uart,
   output logic             wr_uart,
   output logic [DBIT-1:0]  w_data,
   output logic [DBIT-1:0]  last_byte,
   output logic [CNT_W-1:0] byte_cnt,
   output logic             busy,
   output logic             miss
);

   localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BW-1:0] BurstInit = BW'(BURST_LEN - 1);
   localparam logic [1:0] ModeOff   = 2'b00;
   localparam logic [1:0] ModeStep  = 2'b01;
   localparam logic [1:0] ModeAuto  = 2'b10;
   localparam logic [1:0] ModeBurst = 2'b11;

   typedef enum logic [1:0] {StIdle, StPop, StPush} state_e;

   state_e           state_q, state_d;
   logic [BW-1:0]    burst_q, burst_d;
   logic [DBIT-1:0]  hold_q, hold_d;
   logic [DBIT-1:0]  last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             miss_q, miss_d;
   logic             step_mode;

   // Case swap only flips bit 5 of ASCII letters; it degenerates to pass for non-byte widths.
   function automatic logic [DBIT-1:0] apply_xform(input logic [1:0] sel,
                                                   input logic [DBIT-1:0] b);
      logic [DBIT-1:0] res;
      res = b;
      case (sel)
         2'b01:   res = ~b;
         2'b10:   res = b + DBIT'(1);
         2'b11: begin
            if (DBIT == 8) begin
               if ((b >= DBIT'(32'h41) && b <= DBIT'(32'h5A)) ||
                   (b >= DBIT'(32'h61) && b <= DBIT'(32'h7A))) begin
                  res = b ^ DBIT'(32'h20);
               end
            end
         end
         default: res = b;
      endcase
      return res;
   endfunction

   always_comb begin
      state_d   = state_q;
      burst_d   = burst_q;
      hold_d    = hold_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      miss_d    = miss_q;
      rd_uart   = 1'b0;
      wr_uart   = 1'b0;
      w_data    = '0;
      step_mode = (mode == ModeStep) || (mode == ModeBurst);

      unique case (state_q)
         StIdle: begin
            if ((step_mode && step && !rx_empty) || (mode == ModeAuto && !rx_empty)) begin
               state_d = StPop;
               if (mode == ModeBurst) burst_d = BurstInit;
            end
         end
         StPop: begin
            rd_uart = 1'b1;
            hold_d  = apply_xform(xform, r_data);
            state_d = StPush;
         end
         StPush: begin
            w_data  = hold_q;
            wr_uart = !tx_full;
            if (!tx_full) begin
               last_d = hold_q;
               if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
               // Mode sampled now, so a mode change mid-transfer takes effect after this byte.
               if (mode == ModeAuto && !rx_empty) begin
                  state_d = StPop;
               end else if (mode == ModeBurst && burst_q != '0 && !rx_empty) begin
                  burst_d = burst_q - BW'(1);
                  state_d = StPop;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (step_mode && step && (state_q != StIdle || rx_empty)) miss_d = 1'b1;

      if (clr) begin
         cnt_d  = '0;
         miss_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         burst_q <= '0;
         hold_q  <= '0;
         last_q  <= '0;
         cnt_q   <= '0;
         miss_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         burst_q <= burst_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         miss_q  <= miss_d;
      end
   end

   assign last_byte = last_q;
   assign byte_cnt  = cnt_q;
   assign busy      = (state_q != StIdle);
   assign miss      = miss_q;

   logic unused_mode_off;
   assign unused_mode_off = (mode == ModeOff);

endmodule

// File: tb/tb_uart_loop_ctrl.sv
// Bench for uart_loop_ctrl: RX FIFO model, transaction scoreboard, vector table,
// directed corner sequences and a randomized run.
module tb_uart_loop_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] mode = 2'b00, xform = 2'b00;
   logic       step = 1'b0, clr = 1'b0, tx_full = 1'b0;
   logic       rx_empty;
   logic [7:0] r_data;
   logic       rd_uart, wr_uart, busy, miss;
   logic [7:0] w_data, last_byte;
   logic [15:0] byte_cnt;
   logic       rd2, wr2, busy2, miss2;
   logic [7:0] w_data2, last2;
   logic [1:0] byte_cnt2;

   int n_chk = 0, n_err = 0;
   logic [7:0] rx_mem [256];
   int rx_wr = 0, rx_rd = 0, bad_pop = 0;
   logic [7:0] exp_q [$];
   int m_cnt = 0, m_cnt2 = 0;
   logic [7:0] m_last = 8'h00;

   typedef struct {
      logic [1:0] mode;
      logic [1:0] xf;
      logic [7:0] din;
      logic       fire;
      logic [7:0] dout;
   } vec_t;
   vec_t vecs [10];

   uart_loop_ctrl #(.DBIT(8), .CNT_W(16), .BURST_LEN(4)) dut (
      .clk(clk), .reset(reset), .mode(mode), .xform(xform), .step(step), .clr(clr),
      .rx_empty(rx_empty), .r_data(r_data), .tx_full(tx_full), .rd_uart(rd_uart),
      .wr_uart(wr_uart), .w_data(w_data), .last_byte(last_byte), .byte_cnt(byte_cnt),
      .busy(busy), .miss(miss)
   );

   uart_loop_ctrl #(.DBIT(8), .CNT_W(2), .BURST_LEN(4)) dut2 (
      .clk(clk), .reset(reset), .mode(mode), .xform(xform), .step(step), .clr(clr),
      .rx_empty(rx_empty), .r_data(r_data), .tx_full(tx_full), .rd_uart(rd2),
      .wr_uart(wr2), .w_data(w_data2), .last_byte(last2), .byte_cnt(byte_cnt2),
      .busy(busy2), .miss(miss2)
   );

   always #5 clk = ~clk;

   assign rx_empty = (rx_wr == rx_rd);
   assign r_data   = rx_mem[rx_rd[7:0]];

   always @(posedge clk) begin
      if (rd_uart) begin
         if (rx_empty) bad_pop <= bad_pop + 1;
         else rx_rd <= rx_rd + 1;
      end
   end

   function automatic logic [7:0] xf_model(input logic [1:0] sel, input logic [7:0] b);
      int v;
      v = int'(b);
      case (sel)
         2'd0: return b;
         2'd1: return 8'(255 - v);
         2'd2: return 8'((v + 1) % 256);
         default: begin
            if (v >= 65 && v <= 90) return 8'(v + 32);
            if (v >= 97 && v <= 122) return 8'(v - 32);
            return b;
         end
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic rx_push(input logic [7:0] b);
      rx_mem[rx_wr[7:0]] = b;
      rx_wr = rx_wr + 1;
   endtask

   // One clock: observe strobes mid-cycle, let the edge pass, then compare status to the model.
   task automatic tick();
      logic       pw, pc;
      logic [7:0] pd;
      pw = 1'b0;
      pd = 8'h00;
      #1;
      chk("rd_wr_excl", 32'(rd_uart & wr_uart), 32'd0);
      if (rd_uart) begin
         exp_q.push_back(xf_model(xform, r_data));
         chk("pops_pending", 32'(exp_q.size()), 32'd1);
      end
      if (wr_uart) begin
         chk("push_has_pop", 32'(exp_q.size()), 32'd1);
         if (exp_q.size() > 0) begin
            pd = exp_q.pop_front();
            pw = 1'b1;
            chk("w_data", 32'(w_data), 32'(pd));
         end
      end
      pc = clr;
      @(negedge clk);
      if (pc) begin
         m_cnt  = 0;
         m_cnt2 = 0;
      end else if (pw) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt2 < 3) m_cnt2++;
      end
      if (pw) m_last = pd;
      chk("byte_cnt", 32'(byte_cnt), 32'(m_cnt));
      chk("byte_cnt_w2", 32'(byte_cnt2), 32'(m_cnt2));
      chk("last_byte", 32'(last_byte), 32'(m_last));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rd"}, 32'(rd_uart), 32'd0);
      chk({tag, "_wr"}, 32'(wr_uart), 32'd0);
      chk({tag, "_wdata"}, 32'(w_data), 32'd0);
      chk({tag, "_last"}, 32'(last_byte), 32'd0);
      chk({tag, "_cnt"}, 32'(byte_cnt), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_miss"}, 32'(miss), 32'd0);
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      logic [6:0] rd_seen, wr_seen;
      logic [7:0] auto_exp [3];
      int k, np, nw;

      vecs[0] = '{2'b01, 2'b00, 8'h41, 1'b1, 8'h41};
      vecs[1] = '{2'b01, 2'b01, 8'h3C, 1'b1, 8'hC3};
      vecs[2] = '{2'b01, 2'b10, 8'hFF, 1'b1, 8'h00};
      vecs[3] = '{2'b01, 2'b11, 8'h61, 1'b1, 8'h41};
      vecs[4] = '{2'b01, 2'b11, 8'h7B, 1'b1, 8'h7B};
      vecs[5] = '{2'b01, 2'b11, 8'h5A, 1'b1, 8'h7A};
      vecs[6] = '{2'b01, 2'b11, 8'h40, 1'b1, 8'h40};
      vecs[7] = '{2'b11, 2'b00, 8'h99, 1'b1, 8'h99};
      vecs[8] = '{2'b00, 2'b00, 8'h55, 1'b0, 8'h00};
      vecs[9] = '{2'b10, 2'b10, 8'h10, 1'b1, 8'h11};
      auto_exp[0] = 8'h00;
      auto_exp[1] = 8'h11;
      auto_exp[2] = 8'h21;

      #1 reset = 1'b0;
      #1 chk_all_zero("reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Single-byte vectors: strobe timing and transform results.
      foreach (vecs[i]) begin
         rx_push(vecs[i].din);
         mode  = vecs[i].mode;
         xform = vecs[i].xf;
         step  = 1'b1;
         tick();
         step = 1'b0;
         chk("tbl_rd", 32'(rd_uart), 32'(vecs[i].fire));
         chk("tbl_busy", 32'(busy), 32'(vecs[i].fire));
         tick();
         chk("tbl_wr", 32'(wr_uart), 32'(vecs[i].fire));
         chk("tbl_wdata", 32'(w_data), vecs[i].fire ? 32'(vecs[i].dout) : 32'd0);
         tick();
         chk("tbl_idle", 32'(busy), 32'd0);
         chk("tbl_miss", 32'(miss), 32'd0);
         rx_wr = rx_rd;
      end
      mode = 2'b00;

      // Case swap pair, then a step on an empty RX sets miss; clr clears it.
      mode  = 2'b01;
      xform = 2'b11;
      rx_push(8'h61);
      rx_push(8'h7B);
      repeat (2) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         tick();
         tick();
      end
      chk("swap_last", 32'(last_byte), 32'h7B);
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("empty_no_rd", 32'(rd_uart), 32'd0);
      chk("empty_miss", 32'(miss), 32'd1);
      tick();
      clr_pulse();
      chk("clr_miss", 32'(miss), 32'd0);
      chk("clr_cnt", 32'(byte_cnt), 32'd0);

      // AUTO increment: one byte per two cycles; step held high must not set miss.
      rx_push(8'hFF);
      rx_push(8'h10);
      rx_push(8'h20);
      xform = 2'b10;
      mode  = 2'b10;
      step  = 1'b1;
      k = 0;
      for (int i = 0; i < 7; i++) begin
         tick();
         rd_seen[i] = rd_uart;
         wr_seen[i] = wr_uart;
         if (wr_uart && k < 3) begin
            chk("auto_data", 32'(w_data), 32'(auto_exp[k]));
            k++;
         end
      end
      step = 1'b0;
      chk("auto_rd_pat", 32'(rd_seen), 32'b0010101);
      chk("auto_wr_pat", 32'(wr_seen), 32'b0101010);
      chk("auto_cnt", 32'(byte_cnt), 32'd3);
      chk("auto_miss", 32'(miss), 32'd0);
      mode = 2'b00;

      // BURST of 4 from six queued bytes, then a short burst of the remaining two.
      for (int i = 0; i < 6; i++) rx_push(8'(8'hB0 + i));
      xform = 2'b00;
      mode  = 2'b11;
      for (int b = 0; b < 2; b++) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         np = int'(rd_uart);
         nw = int'(wr_uart);
         for (int i = 0; i < 11; i++) begin
            tick();
            np += int'(rd_uart);
            nw += int'(wr_uart);
         end
         chk("burst_pops", 32'(np), b == 0 ? 32'd4 : 32'd2);
         chk("burst_pushes", 32'(nw), b == 0 ? 32'd4 : 32'd2);
         chk("burst_rx_left", 32'(rx_wr - rx_rd), b == 0 ? 32'd2 : 32'd0);
         chk("burst_idle", 32'(busy), 32'd0);
      end

      // TX full stall: hold stable, no push, step during stall sets miss.
      clr_pulse();
      mode  = 2'b01;
      xform = 2'b01;
      rx_push(8'h5E);
      tx_full = 1'b1;
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("stall_rd", 32'(rd_uart), 32'd1);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("stall_wr", 32'(wr_uart), 32'd0);
         chk("stall_hold", 32'(w_data), 32'hA1);
         chk("stall_busy", 32'(busy), 32'd1);
         if (i < 4) begin
            step = (i == 1);
            tick();
         end
      end
      chk("stall_miss", 32'(miss), 32'd1);
      tx_full = 1'b0;
      #1;
      chk("stall_release_wr", 32'(wr_uart), 32'd1);
      chk("stall_release_data", 32'(w_data), 32'hA1);
      tick();
      chk("stall_done", 32'(busy), 32'd0);
      chk("stall_last", 32'(last_byte), 32'hA1);

      // Asynchronous reset while parked in PUSH, then AUTO restarts from POP.
      clr_pulse();
      xform = 2'b00;
      mode  = 2'b10;
      rx_push(8'hC1);
      rx_push(8'hC2);
      tx_full = 1'b1;
      tick();
      tick();
      chk("pre_reset_busy", 32'(busy), 32'd1);
      #2 reset = 1'b0;
      #1 chk_all_zero("async_reset");
      exp_q.delete();
      m_cnt  = 0;
      m_cnt2 = 0;
      m_last = 8'h00;
      tx_full = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("restart_rd", 32'(rd_uart), 32'd1);
      tick();
      chk("restart_wr", 32'(wr_uart), 32'd1);
      chk("restart_data", 32'(w_data), 32'hC2);
      tick();
      mode = 2'b00;

      // Narrow counter saturates at all-ones.
      clr_pulse();
      for (int i = 0; i < 5; i++) rx_push(8'(8'h30 + i));
      mode = 2'b10;
      repeat (12) tick();
      chk("sat_cnt_w2", 32'(byte_cnt2), 32'd3);
      chk("sat_cnt_w16", 32'(byte_cnt), 32'd5);
      mode = 2'b00;

      // Randomized traffic against the scoreboard.
      for (int c = 0; c < 800; c++) begin
         if (c % 40 == 0) mode = 2'($urandom_range(0, 3));
         xform   = 2'($urandom_range(0, 3));
         step    = ($urandom_range(0, 2) == 0);
         tx_full = ($urandom_range(0, 3) == 0);
         clr     = ($urandom_range(0, 30) == 0);
         if ((rx_wr - rx_rd) < 6 && $urandom_range(0, 1) == 1) rx_push(8'($urandom_range(0, 255)));
         tick();
      end
      step    = 1'b0;
      clr     = 1'b0;
      tx_full = 1'b0;
      mode    = 2'b10;
      repeat (40) tick();
      chk("drain_rx_empty", 32'(rx_empty), 32'd1);
      chk("drain_idle", 32'(busy), 32'd0);
      chk("drain_no_pending", 32'(exp_q.size()), 32'd0);
      chk("no_pop_on_empty", 32'(bad_pop), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
